// File: rtl/psram_bridge_pkg.sv
// psram_bridge_pkg: register map, bit indices, FSM states and sizing helper for the PSRAM bridge
package psram_bridge_pkg;

    localparam logic [3:0] REG_NOP      = 4'h0;
    localparam logic [3:0] REG_ADDR0    = 4'h1;
    localparam logic [3:0] REG_ADDR1    = 4'h2;
    localparam logic [3:0] REG_ADDR2    = 4'h3;
    localparam logic [3:0] REG_WDATA0   = 4'h4;
    localparam logic [3:0] REG_WDATA1   = 4'h5;
    localparam logic [3:0] REG_RDATA0   = 4'h6;
    localparam logic [3:0] REG_RDATA1   = 4'h7;
    localparam logic [3:0] REG_START_RD = 4'h8;
    localparam logic [3:0] REG_START_WR = 4'h9;
    localparam logic [3:0] REG_STATUS   = 4'hA;
    localparam logic [3:0] REG_CTRL     = 4'hB;

    localparam int ST_RDY  = 0;
    localparam int ST_DONE = 1;
    localparam int ST_ERR  = 2;

    localparam int CTRL_AUTO_INC = 0;
    localparam int CTRL_IRQ_EN   = 1;
    localparam int CTRL_LB_DIS   = 2;
    localparam int CTRL_UB_DIS   = 3;

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_e;

    function automatic int cnt_width(input int access_cyc, input int recovery_cyc);
        int m;
        m = (access_cyc > recovery_cyc) ? access_cyc : recovery_cyc;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/psram_timing_fsm.sv
// psram_timing_fsm: sequences one access (ACCESS then RECOVER) and drives registered memory strobes
module psram_timing_fsm
    import psram_bridge_pkg::*;
#(
    parameter int ACCESS_CYC   = 5,
    parameter int RECOVERY_CYC = 2
) (
    input  logic Clock,
    input  logic Resetb,
    input  logic start_rd,
    input  logic start_wr,
    output logic CE,
    output logic WE,
    output logic OE,
    output logic DQoe,
    output logic capture,
    output logic done_pulse,
    output logic busy
);

    localparam int CW = cnt_width(ACCESS_CYC, RECOVERY_CYC);

    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic wr_q, wr_d;
    logic ce_q, ce_d, we_q, we_d, oe_q, oe_d, dqoe_q, dqoe_d;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        wr_d       = wr_q;
        capture    = 1'b0;
        done_pulse = 1'b0;
        case (state_q)
            IDLE: if (start_rd || start_wr) begin
                state_d = ACCESS;
                cnt_d   = CW'(ACCESS_CYC - 1);
                wr_d    = start_wr;
            end
            ACCESS: if (cnt_q == '0) begin
                state_d = RECOVER;
                cnt_d   = CW'(RECOVERY_CYC - 1);
                capture = !wr_q;
            end else cnt_d = cnt_q - 1'b1;
            RECOVER: if (cnt_q == '0) begin
                state_d    = IDLE;
                done_pulse = 1'b1;
            end else cnt_d = cnt_q - 1'b1;
            default: state_d = IDLE;
        endcase
        // strobes follow the next state so they switch on the same edge as the FSM
        ce_d   = state_d != ACCESS;
        we_d   = ce_d | !wr_d;
        oe_d   = ce_d | wr_d;
        dqoe_d = !we_d;
    end

    always_ff @(posedge Clock or negedge Resetb) begin
        if (!Resetb) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            ce_q    <= 1'b1;
            we_q    <= 1'b1;
            oe_q    <= 1'b1;
            dqoe_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wr_q    <= wr_d;
            ce_q    <= ce_d;
            we_q    <= we_d;
            oe_q    <= oe_d;
            dqoe_q  <= dqoe_d;
        end
    end

    assign CE   = ce_q;
    assign WE   = we_q;
    assign OE   = oe_q;
    assign DQoe = dqoe_q;
    assign busy = state_q != IDLE;

endmodule

// File: rtl/psram_bus_bridge.sv
// psram_bus_bridge: register-mapped bridge from the 8-bit peripheral bus to asynchronous cellular RAM
module psram_bus_bridge
    import psram_bridge_pkg::*;
#(
    parameter int ADDR_W       = 23,
    parameter int ACCESS_CYC   = 5,
    parameter int RECOVERY_CYC = 2
) (
    input  logic              Clock,
    input  logic              Resetb,
    input  logic              ChipSelect,
    input  logic              Write,
    input  logic              Read,
    input  logic [3:0]        Address,
    input  logic [7:0]        DataIn,
    output logic [7:0]        DataOut,
    output logic              Irq,
    output logic              CE,
    output logic              WE,
    output logic              OE,
    output logic              ADV,
    output logic              CRE,
    output logic              UB,
    output logic              LB,
    output logic [ADDR_W-1:0] AD,
    input  logic [15:0]       DQin,
    output logic [15:0]       DQout,
    output logic              DQoe
);

    logic [ADDR_W-1:0] ad_q, ad_d;
    logic [15:0] dq_q, dq_d, rd_q, rd_d;
    logic [3:0] ctrl_q, ctrl_d;
    logic done_q, done_d, err_q, err_d;
    logic wr, guarded, start_rd, start_wr, capture, done_pulse, busy;
    logic [23:0] ad_ext, ad_w;
    logic [7:0] rdata;

    psram_timing_fsm #(
        .ACCESS_CYC  (ACCESS_CYC),
        .RECOVERY_CYC(RECOVERY_CYC)
    ) u_fsm (
        .Clock     (Clock),
        .Resetb    (Resetb),
        .start_rd  (start_rd),
        .start_wr  (start_wr),
        .CE        (CE),
        .WE        (WE),
        .OE        (OE),
        .DQoe      (DQoe),
        .capture   (capture),
        .done_pulse(done_pulse),
        .busy      (busy)
    );

    assign wr      = ChipSelect & Write;
    assign ad_ext  = 24'(ad_q);
    assign guarded = Address inside {REG_ADDR0, REG_ADDR1, REG_ADDR2, REG_WDATA0, REG_WDATA1,
                                     REG_START_RD, REG_START_WR, REG_CTRL};

    always_comb begin
        dq_d     = dq_q;
        rd_d     = rd_q;
        ctrl_d   = ctrl_q;
        done_d   = done_q;
        err_d    = err_q;
        start_rd = 1'b0;
        start_wr = 1'b0;
        ad_w     = ad_ext;
        if (wr && busy && guarded) err_d = 1'b1;
        else if (wr) begin
            case (Address)
                REG_ADDR0:    ad_w[7:0]   = DataIn;
                REG_ADDR1:    ad_w[15:8]  = DataIn;
                REG_ADDR2:    ad_w[23:16] = DataIn;
                REG_WDATA0:   dq_d[7:0]   = DataIn;
                REG_WDATA1:   dq_d[15:8]  = DataIn;
                REG_START_RD: start_rd    = 1'b1;
                REG_START_WR: start_wr    = 1'b1;
                REG_STATUS: begin
                    if (DataIn[0]) done_d = 1'b0;
                    if (DataIn[1]) err_d  = 1'b0;
                end
                REG_CTRL:     ctrl_d      = DataIn[3:0];
                default: ;
            endcase
        end
        ad_d = ADDR_W'(ad_w);
        if (capture) rd_d = DQin;
        // completion comes last so its DONE set beats a same-cycle clear
        if (done_pulse) begin
            done_d = 1'b1;
            if (ctrl_q[CTRL_AUTO_INC]) ad_d = ad_q + 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetb) begin
        if (!Resetb) begin
            ad_q   <= '0;
            dq_q   <= '0;
            rd_q   <= '0;
            ctrl_q <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ad_q   <= ad_d;
            dq_q   <= dq_d;
            rd_q   <= rd_d;
            ctrl_q <= ctrl_d;
            done_q <= done_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        rdata = 8'h00;
        case (Address)
            REG_ADDR0:  rdata = ad_ext[7:0];
            REG_ADDR1:  rdata = ad_ext[15:8];
            REG_ADDR2:  rdata = ad_ext[23:16];
            REG_WDATA0: rdata = dq_q[7:0];
            REG_WDATA1: rdata = dq_q[15:8];
            REG_RDATA0: rdata = rd_q[7:0];
            REG_RDATA1: rdata = rd_q[15:8];
            REG_STATUS: begin
                rdata[ST_RDY]  = !busy;
                rdata[ST_DONE] = done_q;
                rdata[ST_ERR]  = err_q;
            end
            REG_CTRL:   rdata = {4'b0, ctrl_q};
            default: ;
        endcase
    end

    assign DataOut = (ChipSelect & Read) ? rdata : 8'h00;
    assign Irq     = done_q & ctrl_q[CTRL_IRQ_EN];
    assign UB      = CE | ctrl_q[CTRL_UB_DIS];
    assign LB      = CE | ctrl_q[CTRL_LB_DIS];
    assign ADV     = 1'b0;
    assign CRE     = 1'b0;
    assign AD      = ad_q;
    assign DQout   = dq_q;

endmodule

// File: tb/tb_psram_bus_bridge.sv
// tb_psram_bus_bridge: scoreboard bench with a register-map-level reference model of the bridge
module tb_psram_bus_bridge;

    localparam int AW   = 23;
    localparam int ACC  = 5;
    localparam int REC  = 2;
    localparam int MASK = (1 << AW) - 1;

    logic Clock = 1'b0, Resetb = 1'b1, ChipSelect = 1'b0, Write = 1'b0, Read = 1'b0;
    logic [3:0] Address = 4'h0;
    logic [7:0] DataIn = 8'h00;
    logic [15:0] DQin = 16'h0000;
    logic [7:0] DataOut;
    logic Irq, CE, WE, OE, ADV, CRE, UB, LB, DQoe;
    logic [AW-1:0] AD;
    logic [15:0] DQout;

    psram_bus_bridge #(.ADDR_W(AW), .ACCESS_CYC(ACC), .RECOVERY_CYC(REC)) dut (
        .Clock(Clock), .Resetb(Resetb), .ChipSelect(ChipSelect), .Write(Write), .Read(Read),
        .Address(Address), .DataIn(DataIn), .DataOut(DataOut), .Irq(Irq),
        .CE(CE), .WE(WE), .OE(OE), .ADV(ADV), .CRE(CRE), .UB(UB), .LB(LB),
        .AD(AD), .DQin(DQin), .DQout(DQout), .DQoe(DQoe)
    );

    always #10 Clock = ~Clock;

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: register contents plus the edge number at which the current access began
    int m_ad, m_cyc, m_start;
    logic [15:0] m_dq, m_rd, m_cap;
    logic [3:0] m_ctrl;
    bit m_done, m_err, m_active, m_wr;

    typedef struct {logic [3:0] a; logic [7:0] v;} rd_t;
    typedef struct {bit wr; int ad; logic [15:0] dq; bit ub; bit lb;} acc_t;
    rd_t sb[$];
    acc_t aq[$];

    function automatic logic [7:0] mread(input logic [3:0] a);
        case (a)
            4'h1, 4'h2, 4'h3: return 8'(m_ad >> (8 * (int'(a) - 1)));
            4'h4: return m_dq[7:0];
            4'h5: return m_dq[15:8];
            4'h6: return m_rd[7:0];
            4'h7: return m_rd[15:8];
            4'hA: return {5'b0, m_err, m_done, !m_active};
            4'hB: return {4'b0, m_ctrl};
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_ad = 0; m_dq = 0; m_rd = 0; m_cap = 0; m_ctrl = 0;
        m_done = 0; m_err = 0; m_active = 0; m_wr = 0;
    endtask

    task automatic model_edge(input bit w, input logic [3:0] a, input logic [7:0] d);
        int sh;
        m_cyc++;
        sh = 8 * (int'(a) - 1);
        if (w) begin
            if (m_active && (a inside {4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hB})) m_err = 1;
            else case (a)
                4'h1, 4'h2, 4'h3: m_ad = ((m_ad & ~(255 << sh)) | (int'(d) << sh)) & MASK;
                4'h4: m_dq[7:0] = d;
                4'h5: m_dq[15:8] = d;
                4'h8, 4'h9: begin
                    m_active = 1; m_start = m_cyc; m_wr = (a == 4'h9); m_cap = DQin;
                    aq.push_back('{m_wr, m_ad, m_dq, m_ctrl[3], m_ctrl[2]});
                end
                4'hA: begin
                    if (d[0]) m_done = 0;
                    if (d[1]) m_err = 0;
                end
                4'hB: m_ctrl = d[3:0];
                default: ;
            endcase
        end
        if (m_active && !m_wr && m_cyc == m_start + ACC) m_rd = m_cap;
        if (m_active && m_cyc == m_start + ACC + REC) begin
            m_done = 1;
            if (m_ctrl[0]) m_ad = (m_ad + 1) & MASK;
            m_active = 0;
        end
    endtask

    // one bus cycle: inputs are driven just after a rising edge and sampled at the next one
    task automatic tick(input bit cs, input bit w, input bit r, input logic [3:0] a, input logic [7:0] d);
        ChipSelect = cs; Write = w; Read = r; Address = a; DataIn = d;
        if (cs && r) sb.push_back('{a, mread(a)});
        @(posedge Clock);
        if (Resetb) model_edge(cs && w, a, d);
        #1;
        ChipSelect = 0; Write = 0; Read = 0;
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        tick(1, 1, 0, a, d);
    endtask

    task automatic rd(input logic [3:0] a);
        tick(1, 0, 1, a, 8'h00);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 4'h0, 8'h00);
    endtask

    rd_t e;
    always @(negedge Clock) begin
        if (ChipSelect && Read) begin
            if (sb.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL read_unexpected: got 0x%0h with no expected value", DataOut);
            end else begin
                e = sb.pop_front();
                chk($sformatf("read_reg%0h", e.a), 32'(DataOut), 32'(e.v));
            end
        end
        chk("irq", 32'(Irq), 32'(m_done && m_ctrl[1]));
        chk("adv_cre", 32'({ADV, CRE}), 32'(0));
        if (CE) chk("idle_strobes", 32'({WE, OE, UB, LB, DQoe}), 32'(5'b11110));
    end

    acc_t cur;
    int run = 0;
    always @(negedge Clock or negedge Resetb) begin
        if (!Resetb) run = 0;
        else if (!CE) begin
            if (run == 0) begin
                if (aq.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL access_unexpected: got CE low with no access expected");
                    cur = '{0, 0, 16'h0, 0, 0};
                end else cur = aq.pop_front();
            end
            run++;
            chk("acc_we", 32'(WE), 32'(!cur.wr));
            chk("acc_oe", 32'(OE), 32'(cur.wr));
            chk("acc_dqoe", 32'(DQoe), 32'(cur.wr));
            chk("acc_ub", 32'(UB), 32'(cur.ub));
            chk("acc_lb", 32'(LB), 32'(cur.lb));
            chk("acc_ad", 32'(AD), cur.ad);
            chk("acc_dqout", 32'(DQout), 32'(cur.dq));
        end else if (run != 0) begin
            chk("acc_len", run, ACC);
            run = 0;
        end
    end

    int k;
    logic [3:0] ra;
    logic [7:0] rdv;
    initial begin
        model_reset();
        m_cyc = 0;
        #1 Resetb = 0;
        repeat (2) @(posedge Clock);
        #1 Resetb = 1;
        for (int a = 0; a < 16; a++) rd(4'(a));
        // write access
        wr(4'h1, 8'h34); wr(4'h2, 8'h12); wr(4'h3, 8'h00); wr(4'h4, 8'hCD); wr(4'h5, 8'hAB);
        wr(4'h9, 8'h00);
        repeat (8) rd(4'hA);
        for (int a = 1; a <= 5; a++) rd(4'(a));
        // read access
        DQin = 16'hBEEF;
        wr(4'h8, 8'h00);
        repeat (8) rd(4'hA);
        rd(4'h6); rd(4'h7);
        // auto-increment wrap
        wr(4'hA, 8'h01); wr(4'hB, 8'h01);
        wr(4'h1, 8'hFF); wr(4'h2, 8'hFF); wr(4'h3, 8'hFF);
        rd(4'h3);
        wr(4'h8, 8'h00); idle(8); rd(4'h1); rd(4'h2); rd(4'h3);
        wr(4'h8, 8'h00); idle(8); rd(4'h1); rd(4'h2); rd(4'h3);
        // busy error
        wr(4'hB, 8'h00); wr(4'hA, 8'h03);
        wr(4'h9, 8'h00); idle(1); wr(4'h1, 8'h55);
        rd(4'hA); idle(7); rd(4'hA); rd(4'h1);
        wr(4'hA, 8'h02); rd(4'hA);
        // irq and clear race on the completion edge
        wr(4'hA, 8'h01); wr(4'hB, 8'h02);
        wr(4'h8, 8'h00); idle(6); wr(4'hA, 8'h01);
        rd(4'hA); idle(2); wr(4'hA, 8'h01); rd(4'hA); idle(1);
        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            k = $urandom_range(0, 9);
            ra = 4'($urandom_range(0, 15));
            rdv = 8'($urandom);
            if (!m_active && $urandom_range(0, 3) == 0) DQin = 16'($urandom);
            case (k)
                0, 1, 2: rd(ra);
                3, 4, 5: wr(ra, rdv);
                6: wr(4'(8 + $urandom_range(0, 1)), rdv);
                7: tick(0, 1, 0, ra, rdv);
                8: idle(1);
                default: wr(4'hA, rdv);
            endcase
        end
        idle(10);
        // asynchronous reset in the third ACCESS cycle
        wr(4'hB, 8'h0F); wr(4'h1, 8'h5A); wr(4'h4, 8'h77); wr(4'h9, 8'h00);
        idle(2);
        #2 Resetb = 0;
        model_reset();
        #1;
        chk("rst_ce", 32'(CE), 32'(1));
        chk("rst_we", 32'(WE), 32'(1));
        chk("rst_oe", 32'(OE), 32'(1));
        chk("rst_dqoe", 32'(DQoe), 32'(0));
        @(posedge Clock);
        #1 Resetb = 1;
        for (int a = 0; a < 16; a++) rd(4'(a));
        idle(2);
        chk("sb_drained", sb.size(), 0);
        chk("acc_drained", aq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
